// File: rtl/fan_ramp_ctrl.sv
// fan_ramp_ctrl: slewed fan speed control with clamp, power-loss cut-off and auto-off timer (optional kick-start via FAN_KICKSTART_EN)
module fan_ramp_ctrl #(
   parameter int SPEED_W   = 3,
   parameter int MAX_SPEED = 5,
   parameter int RAMP_DIV  = 4,
   parameter int TIMER_W   = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               elec,
   input  logic [SPEED_W-1:0] mod,
   input  logic               timer_load,
   input  logic [TIMER_W-1:0] timer_val,
   output logic [SPEED_W-1:0] speed,
   output logic               running,
   output logic               at_target
);
   localparam int DIV_W = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
   localparam logic [SPEED_W-1:0] MAX_S = SPEED_W'(MAX_SPEED);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RAMP_DIV - 1);
   typedef enum logic [2:0] {OFF, RAMP_UP, RAMP_DOWN, HOLD, KICK} state_t;
   state_t r_state, w_state_next;
   logic [SPEED_W-1:0] r_speed, w_speed_next, w_target;
   logic [DIV_W-1:0]   r_div, w_div_next;
   logic [TIMER_W-1:0] r_rem, w_rem_next;
   logic               r_expired, w_expired_next, w_step;
`ifdef FAN_KICKSTART_EN
   localparam int KW = $clog2(2 * RAMP_DIV) + 1;
   localparam logic [KW-1:0] KICK_LOAD = KW'(2 * RAMP_DIV - 1);
   logic [KW-1:0] r_kick, w_kick_next;
`endif
   // state register; reset forces the fan off without waiting for a clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= OFF;
         r_speed   <= '0;
         r_div     <= '0;
         r_rem     <= '0;
         r_expired <= 1'b0;
`ifdef FAN_KICKSTART_EN
         r_kick    <= '0;
`endif
      end else begin
         r_state   <= w_state_next;
         r_speed   <= w_speed_next;
         r_div     <= w_div_next;
         r_rem     <= w_rem_next;
         r_expired <= w_expired_next;
`ifdef FAN_KICKSTART_EN
         r_kick    <= w_kick_next;
`endif
      end
   end
   // target clamp, one-level slew, timer countdown and next-state classification
   always_comb begin
      w_target       = (!elec || r_expired || mod == '0) ? '0 : (mod > MAX_S ? MAX_S : mod);
      w_step         = (r_speed != w_target) && (r_div == DIV_LAST);
      w_div_next     = (r_speed == w_target || r_div == DIV_LAST) ? '0 : r_div + 1'b1;
      w_speed_next   = !w_step ? r_speed : (r_speed < w_target ? r_speed + 1'b1 : r_speed - 1'b1);
      w_rem_next     = !elec ? '0 : timer_load ? timer_val : (r_rem != '0 ? r_rem - 1'b1 : r_rem);
      w_expired_next = (!elec || timer_load) ? 1'b0 : (r_rem == TIMER_W'(1)) ? 1'b1 : (mod == '0) ? 1'b0 : r_expired;
`ifdef FAN_KICKSTART_EN
      w_kick_next    = '0;
      if (r_state == OFF && w_target != '0) begin
         w_speed_next = MAX_S;
         w_div_next   = '0;
         w_kick_next  = KICK_LOAD;
      end else if (r_state == KICK && w_target != '0 && r_kick != '0) begin
         w_speed_next = r_speed;
         w_div_next   = '0;
         w_kick_next  = r_kick - 1'b1;
      end
`endif
      if (!elec) begin
         w_speed_next = '0;
         w_div_next   = '0;
`ifdef FAN_KICKSTART_EN
         w_kick_next  = '0;
`endif
      end
      w_state_next = (w_speed_next == '0 && w_target == '0) ? OFF :
                     (w_speed_next < w_target) ? RAMP_UP :
                     (w_speed_next > w_target) ? RAMP_DOWN : HOLD;
`ifdef FAN_KICKSTART_EN
      if (w_kick_next != '0 || (r_state == OFF && w_target != '0 && elec)) w_state_next = KICK;
`endif
   end
   assign speed     = r_speed;
   assign running   = r_speed != '0;
   assign at_target = r_speed == w_target;
endmodule
